// File: rtl/csr_counter_ctrl.sv
// rtl/csr_counter_ctrl.sv - cycle/instret counter CSR controller with req/ack access FSM
// Define CSR_CNT_INHIBIT_EN to implement mcountinhibit at 0x320; otherwise counters always run.
module csr_counter_ctrl #(
   parameter int                XLEN        = 32,
   parameter logic [2*XLEN-1:0] CYCLE_RST   = '0,
   parameter logic [2*XLEN-1:0] INSTRET_RST = '0
) (
   input  logic            clk,
   input  logic            nreset,
   input  logic            csr_req,
   input  logic [11:0]     csr_addr,
   input  logic [1:0]      csr_rw_mode,
   input  logic [XLEN-1:0] csr_wdata,
   input  logic            instr_retired,
   output logic [XLEN-1:0] csr_rdata,
   output logic            csr_ack,
   output logic            csr_illegal
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_COMMIT, S_RESP} state_t;
   typedef enum logic [2:0] {T_NONE, T_CYC_LO, T_CYC_HI, T_IR_LO, T_IR_HI, T_INH} tgt_t;

   localparam logic [2*XLEN-1:0] CNT_ONE = {{(2*XLEN-1){1'b0}}, 1'b1};

   state_t            state_q;
   state_t            state_d;
   logic [11:0]       addr_q;
   logic [1:0]        mode_q;
   logic [XLEN-1:0]   wdata_q;
   tgt_t              tgt_q;
   tgt_t              tgt_d;
   logic              ro_d;
   logic              illegal_d;
   logic [XLEN-1:0]   old_d;
   logic [XLEN-1:0]   new_d;
   logic [XLEN-1:0]   new_q;
   logic [2*XLEN-1:0] cycle_q;
   logic [2*XLEN-1:0] instret_q;
   logic              inh_cy;
   logic              inh_ir;
   logic              commit;

   assign commit  = (state_q == S_COMMIT);
   assign csr_ack = (state_q == S_RESP);

`ifdef CSR_CNT_INHIBIT_EN
   localparam logic [XLEN-1:0] INH_MASK = {{(XLEN-3){1'b0}}, 3'b101};

   logic [XLEN-1:0] inhibit_q;

   assign inh_cy = inhibit_q[0];
   assign inh_ir = inhibit_q[2];

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         inhibit_q <= '0;
      end else if (commit && tgt_q == T_INH) begin
         inhibit_q <= new_q & INH_MASK;
      end
   end
`else
   assign inh_cy = 1'b0;
   assign inh_ir = 1'b0;
`endif

   // Read-only user aliases share targets with their machine counterparts.
   always_comb begin
      tgt_d = T_NONE;
      ro_d  = 1'b0;
      case (addr_q)
         12'hC00: begin tgt_d = T_CYC_LO; ro_d = 1'b1; end
         12'hC80: begin tgt_d = T_CYC_HI; ro_d = 1'b1; end
         12'hC02: begin tgt_d = T_IR_LO;  ro_d = 1'b1; end
         12'hC82: begin tgt_d = T_IR_HI;  ro_d = 1'b1; end
         12'hB00: tgt_d = T_CYC_LO;
         12'hB80: tgt_d = T_CYC_HI;
         12'hB02: tgt_d = T_IR_LO;
         12'hB82: tgt_d = T_IR_HI;
`ifdef CSR_CNT_INHIBIT_EN
         12'h320: tgt_d = T_INH;
`endif
         default: tgt_d = T_NONE;
      endcase
   end

   always_comb begin
      old_d = '0;
      case (tgt_d)
         T_CYC_LO: old_d = cycle_q[XLEN-1:0];
         T_CYC_HI: old_d = cycle_q[2*XLEN-1:XLEN];
         T_IR_LO:  old_d = instret_q[XLEN-1:0];
         T_IR_HI:  old_d = instret_q[2*XLEN-1:XLEN];
`ifdef CSR_CNT_INHIBIT_EN
         T_INH:    old_d = inhibit_q;
`endif
         default:  old_d = '0;
      endcase
   end

   always_comb begin
      illegal_d = (tgt_d == T_NONE) || (ro_d && mode_q != 2'b00);
      new_d     = old_d;
      case (mode_q)
         2'b01:   new_d = wdata_q;
         2'b10:   new_d = old_d | wdata_q;
         2'b11:   new_d = old_d & ~wdata_q;
         default: new_d = old_d;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (csr_req) state_d = S_ACCESS;
         S_ACCESS: state_d = (!illegal_d && mode_q != 2'b00) ? S_COMMIT : S_RESP;
         S_COMMIT: state_d = S_RESP;
         S_RESP:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         addr_q      <= '0;
         mode_q      <= '0;
         wdata_q     <= '0;
         tgt_q       <= T_NONE;
         new_q       <= '0;
         csr_rdata   <= '0;
         csr_illegal <= 1'b0;
      end else begin
         if (state_q == S_IDLE && csr_req) begin
            addr_q  <= csr_addr;
            mode_q  <= csr_rw_mode;
            wdata_q <= csr_wdata;
         end
         if (state_q == S_ACCESS) begin
            csr_rdata   <= illegal_d ? '0 : old_d;
            csr_illegal <= illegal_d;
            tgt_q       <= illegal_d ? T_NONE : tgt_d;
            new_q       <= new_d;
         end
      end
   end

   // A committed half is written exactly; the whole counter skips its increment that edge.
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         cycle_q <= CYCLE_RST;
      end else if (commit && tgt_q == T_CYC_LO) begin
         cycle_q[XLEN-1:0] <= new_q;
      end else if (commit && tgt_q == T_CYC_HI) begin
         cycle_q[2*XLEN-1:XLEN] <= new_q;
      end else if (!inh_cy) begin
         cycle_q <= cycle_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         instret_q <= INSTRET_RST;
      end else if (commit && tgt_q == T_IR_LO) begin
         instret_q[XLEN-1:0] <= new_q;
      end else if (commit && tgt_q == T_IR_HI) begin
         instret_q[2*XLEN-1:XLEN] <= new_q;
      end else if (instr_retired && !inh_ir) begin
         instret_q <= instret_q + CNT_ONE;
      end
   end

endmodule
